// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default sizes for the multiplier scheduler
package mult_pkg;
  localparam int MULT_N_REQ = 2;
  localparam int MULT_WIDTH = 4;
  typedef enum logic [5:0] {
    IdleS  = 6'b000001,
    LoadS  = 6'b000010,
    TestS  = 6'b000100,
    AddS   = 6'b001000,
    ShiftS = 6'b010000,
    DoneS  = 6'b100000
  } mult_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping modulo N_REQ
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = MULT_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] win,
  output logic                     found
);
  localparam int SW = $clog2(N_REQ);
  // scan from the farthest offset down so the nearest requester after ptr wins
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        win = SW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sequencer driving a shared shift-add multiplier datapath
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int N_REQ = MULT_N_REQ,
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         req,
  input  logic                     Q0,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     Load,
  output logic                     Add,
  output logic                     Shift,
  output logic [N_REQ-1:0]         done,
  output logic                     Busy
);
  localparam int SW = $clog2(N_REQ);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [SW-1:0] TOP = SW'(N_REQ - 1);
  mult_state_t state, next;
  logic [CW-1:0] cnt;
  logic [SW-1:0] ptr, win;
  logic found;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .win(win),
    .found(found)
  );
  // next-state logic; arbitration only matters while idle
  always_comb begin
    next = state;
    case (state)
      IdleS:   next = found ? LoadS : IdleS;
      LoadS:   next = TestS;
      TestS:   next = Q0 ? AddS : ShiftS;
      AddS:    next = ShiftS;
      ShiftS:  next = (cnt == LAST) ? DoneS : TestS;
      DoneS:   next = IdleS;
      default: next = IdleS;
    endcase
  end
  // state, iteration counter, grant index and round-robin pointer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IdleS;
      cnt <= '0;
      ptr <= '0;
      sel <= '0;
    end else begin
      state <= next;
      if (state == IdleS && found) sel <= win;
      if (state == LoadS) cnt <= '0;
      else if (state == ShiftS && cnt != LAST) cnt <= cnt + 1'b1;
      if (state == ShiftS && cnt == LAST) ptr <= (sel == TOP) ? '0 : sel + 1'b1;
    end
  end
  // Moore output decode; gnt is rebuilt from sel so it is zero whenever idle
  always_comb begin
    Busy = state != IdleS;
    Load = state == LoadS;
    Add = state == AddS;
    Shift = state == ShiftS;
    gnt = Busy ? {{(N_REQ - 1){1'b0}}, 1'b1} << sel : '0;
    done = (state == DoneS) ? gnt : '0;
  end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: table, directed and random checks of the scheduler against a cycle-stream model
module tb_mult_scheduler;
  localparam int N_REQ = 2;
  localparam int WIDTH = 4;
  localparam int SW = $clog2(N_REQ);
  localparam int VW = N_REQ + SW + 3 + N_REQ + 1;
  typedef struct {
    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] m;
    int client;
    int len;
  } vec_t;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic Q0;
  logic [N_REQ-1:0] gnt, done;
  logic [SW-1:0] sel;
  logic Load, Add, Shift, Busy;
  logic [WIDTH-1:0] mul [N_REQ];
  logic [WIDTH-1:0] mreg = '0;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  mult_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .req(req),
    .Q0(Q0),
    .gnt(gnt),
    .sel(sel),
    .Load(Load),
    .Add(Add),
    .Shift(Shift),
    .done(done),
    .Busy(Busy)
  );
  always #5 Clock = ~Clock;
  // stand-in datapath multiplier register feeding Q0
  always @(posedge Clock) begin
    if (Load) mreg <= mul[sel];
    else if (Shift) mreg <= mreg >> 1;
  end
  assign Q0 = mreg[0];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic logic [VW-1:0] act();
    return {gnt, sel, Load, Add, Shift, done, Busy};
  endfunction
  function automatic logic [VW-1:0] vec(input int c, input byte s, input bit b);
    logic [N_REQ-1:0] g;
    g = b ? N_REQ'(1) << c : '0;
    return {g, SW'(c), s == "L", s == "A", s == "S", (s == "D") ? g : N_REQ'(0), b};
  endfunction
  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return 0;
  endfunction
  task automatic expect_op(input string nm, input int c, input logic [WIDTH-1:0] m,
                           input int max_wait, output int len);
    byte q[$];
    int n;
    q.push_back("L");
    for (int i = 0; i < WIDTH; i++) begin
      q.push_back("T");
      if (m[i]) q.push_back("A");
      q.push_back("S");
    end
    q.push_back("D");
    n = 0;
    while (!Busy && n < max_wait) begin
      @(negedge Clock);
      n++;
    end
    chk({nm, "_start"}, 32'(Busy), 32'd1);
    len = 0;
    while (Busy && len < 3 * WIDTH + 8) begin
      chk($sformatf("%s_cyc%0d", nm, len), 32'(act()),
          32'((len < q.size()) ? vec(c, q[len], 1'b1) : vec(c, "I", 1'b0)));
      len++;
      @(negedge Clock);
    end
    chk({nm, "_idle"}, 32'(act()), 32'(vec(c, "I", 1'b0)));
    chk({nm, "_len"}, len, q.size());
  endtask
  initial begin
    vec_t tbl[7];
    int len, c, n, gap;
    logic [N_REQ-1:0] r;
    tbl[0] = '{2'b01, 4'b1011, 0, 13};
    tbl[1] = '{2'b11, 4'b0000, 1, 10};
    tbl[2] = '{2'b11, 4'b1111, 0, 14};
    tbl[3] = '{2'b11, 4'b0110, 1, 12};
    tbl[4] = '{2'b10, 4'b0001, 1, 11};
    tbl[5] = '{2'b11, 4'b1000, 0, 11};
    tbl[6] = '{2'b11, 4'b0101, 1, 12};
    mul[0] = '0;
    mul[1] = '0;
    repeat (2) @(negedge Clock);
    chk("reset_state", 32'(act()), 32'(vec(0, "I", 1'b0)));
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_no_req", 32'(act()), 32'(vec(0, "I", 1'b0)));
    for (int t = 0; t < 7; t++) begin
      req = tbl[t].req;
      mul[0] = tbl[t].m;
      mul[1] = tbl[t].m;
      c = pick(req, mptr);
      expect_op($sformatf("tbl%0d", t), c, tbl[t].m, 1, len);
      chk($sformatf("tbl%0d_sel", t), 32'(sel), tbl[t].client);
      chk($sformatf("tbl%0d_oplen", t), len, tbl[t].len);
      mptr = (c + 1) % N_REQ;
    end
    req = 2'b01;
    mul[0] = 4'b1001;
    mul[1] = 4'b0011;
    c = pick(req, mptr);
    fork
      expect_op("drop", c, mul[c], 1, len);
      begin
        repeat (2) @(negedge Clock);
        req[0] = 1'b0;
        @(negedge Clock);
        req[1] = 1'b1;
      end
    join
    chk("drop_client", 32'(sel), 32'd0);
    mptr = (c + 1) % N_REQ;
    c = pick(req, mptr);
    expect_op("late", c, mul[c], 1, len);
    chk("late_client", 32'(sel), 32'd1);
    mptr = (c + 1) % N_REQ;
    req = 2'b11;
    mul[0] = 4'b1011;
    mul[1] = 4'b1011;
    n = 0;
    while (!Add && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("rst_add_seen", 32'(Add), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_async", 32'(act()), 32'(vec(0, "I", 1'b0)));
    @(negedge Clock);
    chk("rst_held", 32'(act()), 32'(vec(0, "I", 1'b0)));
    Reset = 1'b0;
    mptr = 0;
    c = pick(req, mptr);
    expect_op("after_rst", c, mul[c], 1, len);
    chk("after_rst_client", 32'(sel), 32'd0);
    mptr = (c + 1) % N_REQ;
    for (int it = 0; it < 30; it++) begin
      r = N_REQ'($urandom_range(0, 2 ** N_REQ - 1));
      if (r == 0) begin
        req = '0;
        gap = $urandom_range(1, 3);
        repeat (gap) begin
          @(negedge Clock);
          chk("rand_idle", 32'(act()), 32'(vec(int'(sel), "I", 1'b0)));
        end
        r = N_REQ'($urandom_range(1, 2 ** N_REQ - 1));
      end
      for (int k = 0; k < N_REQ; k++) mul[k] = WIDTH'($urandom);
      req = r;
      c = pick(r, mptr);
      expect_op($sformatf("rand%0d", it), c, mul[c], 1, len);
      mptr = (c + 1) % N_REQ;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Sequencer and round-robin arbiter for the shared shift-add multiplier datapath. Accepts multiply requests from up to N_REQ clients, grants the datapath to one at a time, and drives the datapath's Load/Add/Shift strobes for WIDTH iterations. It pulses a per-client done when the product register is valid. It sits between the client blocks and the multiplier datapath, replacing the fixed-iteration controller wherever the datapath is shared.

## Interface
- N_REQ, default 2: number of requesting clients, range 2..8.
- WIDTH, default 4: multiplier operand width, which equals the number of shift iterations; range 2..16.
- Clock  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-client request level; the client holds it high until its done pulse.
- Q0  input  1  LSB of the datapath multiplier register.
- gnt  output  N_REQ  one-hot grant; it is all-zero when idle.
- sel  output  $clog2(N_REQ)  operand mux select, equal to the index of the granted client; it holds its last value when idle.
- Load  output  1  load operands into the datapath; active in LoadS.
- Add  output  1  add the multiplicand into the accumulator; active in AddS.
- Shift  output  1  shift the accumulator/multiplier right; active in ShiftS.
- done  output  N_REQ  one-cycle pulse on the granted client's bit; active in DoneS.
- Busy  output  1  high in every state except IdleS.

## Operation
- Moore FSM with six states: IdleS, LoadS, TestS, AddS, ShiftS, DoneS.
- State transitions:
  - IdleS: if any req bit is high, go to LoadS. Otherwise stay in IdleS.
  - LoadS: go to TestS.
  - TestS: if Q0 is 1, go to AddS. Otherwise go to ShiftS.
  - AddS: go to ShiftS.
  - ShiftS: if the iteration counter equals WIDTH-1, go to DoneS. Otherwise increment the counter and go to TestS.
  - DoneS: go to IdleS, unconditionally.
- Iteration counter:
  - Width is $clog2(WIDTH) bits.
  - It is cleared in LoadS and incremented only on ShiftS exits to TestS.
- Arbitration:
  - Evaluated only in IdleS.
  - Round-robin search starts at index ptr and wraps modulo N_REQ. The first requester found wins.
  - The winner index is registered into sel and gnt on entry to LoadS.
  - ptr is updated to winner+1 (mod N_REQ) on entry to DoneS.
- Grant stability:
  - gnt and sel are held constant from LoadS through DoneS inclusive.
  - Requests arriving mid-operation are ignored until the next IdleS.
- Dropped request:
  - If the granted client deasserts req mid-operation, the operation still completes.
  - The done pulse is still issued, and ptr still advances.
- All outputs are registered-state decodes; there is no combinational path from req or Q0 to any output.

## Timing
- Reset value of every register and output:
  - state = IdleS, ptr = 0, counter = 0, sel = 0.
  - gnt, done, Load, Add, Shift and Busy are all 0.
- Reset asserted mid-operation:
  - All outputs drop to 0 asynchronously.
  - No done pulse is issued, and ptr returns to 0.
- Request to Load:
  - req is sampled high in IdleS at edge k; Load and gnt are high in cycle k+1.
- Cycles per operation from LoadS through DoneS inclusive: 2 + 2·WIDTH + (number of 1 bits in the multiplier).
  - Minimum: 2+2·WIDTH.
  - Maximum: 2+3·WIDTH.
- Q0 is sampled at the TestS exit edge and must be stable in TestS (it is valid after Load or Shift).
- Back-to-back operations:
  - DoneS is always followed by exactly one IdleS cycle.
  - The next LoadS is therefore at the earliest 2 cycles after DoneS starts.
- Simultaneous requests in IdleS: ptr decides; after ptr wraps past N_REQ-1 it returns to 0.
- Exactly one of Load/Add/Shift/done is high in any non-Idle, non-Test cycle. All four are low in TestS and IdleS.

## Structure
- mult_pkg holds:
  - The state enum type (mult_state_t), one-hot encoded as 6'b000001..6'b100000.
  - Default constants MULT_N_REQ and MULT_WIDTH.
- Sub-module rr_arbiter:
  - Combinational round-robin pick: takes req and ptr, returns the winner index and a found flag.
  - Parameterized by N_REQ.
  - The pointer register stays in mult_scheduler.

## Test plan
- Reset, then a single request: after Reset, hold req=2'b01 with WIDTH=4 and the multiplier 4'b1011 driving Q0. Required: Load 1 cycle after the sample, three Add pulses, four Shift pulses, done=2'b01 on cycle 13 of the operation, and Busy=0 in the following cycle.
- Both clients requesting: hold req=2'b11 continuously. Required: grants alternate 01, 10, 01, 10, each followed by its done pulse, with exactly one IdleS cycle between operations.
- Zero multiplier: Q0 is held 0 throughout. Required: no Add pulse, operation length 2+2·WIDTH = 10 cycles, and done asserted.
- All-ones multiplier: Q0 is held 1 throughout. Required: operation length 2+3·WIDTH = 14 cycles, with Add immediately preceding every Shift.
- Dropped request and late arrival:
  - Client 0 is granted, drops req in cycle 3, and client 1 raises req in cycle 4.
  - Required: client 0 still gets done, gnt never changes mid-operation, and client 1 is granted next.
- Reset mid-operation:
  - Assert Reset during AddS.
  - Required: all outputs are 0 immediately with no done pulse. After release with req=2'b11, client 0 is granted first (ptr=0).
